// File: rtl/dac7611_pkg.sv
// Shared definitions for the DAC7611 serial receive-side monitor:
// pin-bundle bit positions, word width, FSM states and a small helper.
package dac7611_pkg;

    // Bit positions inside the 4-wire pin bundle
    localparam int DAC_CLK = 3;
    localparam int DAC_SDI = 2;
    localparam int DAC_LD  = 1;
    localparam int DAC_CLR = 0;

    // DAC7611 data word width
    localparam int DAC7611_WIDTH = 12;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_CLEAR = 2'd3
    } dac_state_e;

    // 4-bit increment that sticks at 15 so over-long frames stay detectable
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) begin
            r = 4'd15;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dac7611_serial_monitor_sync_edge.sv
// N-bit two-flop synchronizer followed by one delay stage; reports the
// synchronized level plus single-cycle rise and fall indications per bit.
module sync_edge #(
    parameter int           N       = 4,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] meta_r;
    logic [N-1:0] sync_r;
    logic [N-1:0] dly_r;

    // Synchronizer chain and edge-detect delay, reset to the idle pin levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            dly_r  <= RST_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~dly_r;
    assign fall  = ~sync_r & dly_r;

endmodule

// File: rtl/dac7611_serial_monitor.sv
// Receive-side model of the DAC7611 3-wire serial port plus CLR. Shifts SDI
// in MSB-first on CLK rise, latches the word on LD fall, flags bad frames.
module dac7611_serial_monitor
    import dac7611_pkg::*;
#(
    parameter int DATA_W = DAC7611_WIDTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        dac_signals,
    output logic [DATA_W-1:0] dac_code,
    output logic              code_valid,
    output logic              frame_err,
    output logic              clr_seen,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_W);
    // Idle pin levels: CLK=1, SDI=0, LD=1, CLR=1
    localparam logic [3:0] PIN_IDLE = 4'b1011;

    logic [3:0] lvl_s;
    logic [3:0] rise_s;
    logic [3:0] fall_s;

    logic clk_rise_s;
    logic sdi_lvl_s;
    logic ld_lvl_s;
    logic ld_fall_s;
    logic ld_prev_s;
    logic clr_lvl_s;
    logic clr_fall_s;
    logic unused_s;

    dac_state_e        state_r;
    dac_state_e        state_nxt_s;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_nxt_s;
    logic [3:0]        bit_cnt_r;
    logic [3:0]        bit_cnt_nxt_s;
    logic [DATA_W-1:0] dac_code_r;
    logic [DATA_W-1:0] code_nxt_s;
    logic              code_valid_r;
    logic              valid_nxt_s;
    logic              frame_err_r;
    logic              err_nxt_s;
    logic              clr_seen_r;
    logic              clr_nxt_s;
    logic              busy_r;
    logic [CNT_W-1:0]  frame_count_r;
    logic [CNT_W-1:0]  fcnt_nxt_s;

    sync_edge #(
        .N       (4),
        .RST_VAL (PIN_IDLE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (dac_signals),
        .level   (lvl_s),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    assign clk_rise_s = rise_s[DAC_CLK];
    assign sdi_lvl_s  = lvl_s[DAC_SDI];
    assign ld_lvl_s   = lvl_s[DAC_LD];
    assign ld_fall_s  = fall_s[DAC_LD];
    // LD level one sample earlier: a CLK rise coinciding with LD fall still shifts
    assign ld_prev_s  = ld_lvl_s | ld_fall_s;
    assign clr_lvl_s  = lvl_s[DAC_CLR];
    assign clr_fall_s = fall_s[DAC_CLR];
    assign unused_s   = ^{rise_s[DAC_SDI], rise_s[DAC_LD], rise_s[DAC_CLR],
                          fall_s[DAC_CLK], fall_s[DAC_SDI], lvl_s[DAC_CLK]};

    // Next-state datapath: CLR level dominates, otherwise shift then load
    always_comb begin
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        code_nxt_s    = dac_code_r;
        valid_nxt_s   = 1'b0;
        err_nxt_s     = 1'b0;
        clr_nxt_s     = 1'b0;
        fcnt_nxt_s    = frame_count_r;

        if (!clr_lvl_s) begin
            shreg_nxt_s   = '0;
            bit_cnt_nxt_s = 4'd0;
            code_nxt_s    = '0;
            clr_nxt_s     = clr_fall_s;
            state_nxt_s   = ST_CLEAR;
        end else begin
            // Bit capture comes first so a same-cycle load sees the new bit
            if (clk_rise_s) begin
                if (ld_prev_s) begin
                    shreg_nxt_s   = {shreg_r[DATA_W-2:0], sdi_lvl_s};
                    bit_cnt_nxt_s = sat_inc4(bit_cnt_r);
                end else begin
                    err_nxt_s = 1'b1;
                end
            end else begin
                shreg_nxt_s = shreg_r;
            end

            if (ld_fall_s) begin
                if (bit_cnt_nxt_s >= FULL_CNT) begin
                    code_nxt_s  = shreg_nxt_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    code_nxt_s = dac_code_r;
                end
                if (bit_cnt_nxt_s == FULL_CNT) begin
                    fcnt_nxt_s = frame_count_r + CNT_W'(1'b1);
                end else begin
                    err_nxt_s = 1'b1;
                end
                bit_cnt_nxt_s = 4'd0;
            end else begin
                fcnt_nxt_s = frame_count_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (ld_fall_s) begin
                        state_nxt_s = ST_HOLD;
                    end else if (clk_rise_s && ld_prev_s) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (ld_fall_s) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    // Level test rather than edge so the FSM can never stick here
                    if (ld_lvl_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_CLEAR: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            shreg_r       <= '0;
            bit_cnt_r     <= 4'd0;
            dac_code_r    <= '0;
            code_valid_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            clr_seen_r    <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= '0;
        end else begin
            state_r       <= state_nxt_s;
            shreg_r       <= shreg_nxt_s;
            bit_cnt_r     <= bit_cnt_nxt_s;
            dac_code_r    <= code_nxt_s;
            code_valid_r  <= valid_nxt_s;
            frame_err_r   <= err_nxt_s;
            clr_seen_r    <= clr_nxt_s;
            busy_r        <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_HOLD);
            frame_count_r <= fcnt_nxt_s;
        end
    end

    assign dac_code    = dac_code_r;
    assign code_valid  = code_valid_r;
    assign frame_err   = frame_err_r;
    assign clr_seen    = clr_seen_r;
    assign busy        = busy_r;
    assign frame_count = frame_count_r;

endmodule
